// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature display scanner:
// FSM encoding, digit slots, segment codes and the double-dabble step.
package temp_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] DIG_HUND = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_ONES = 2'd2;
    localparam logic [1:0] DIG_UNIT = 2'd3;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Any code above 9 decodes to a dark digit.
    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] ITER_COUNT = 4'd8;

    // One double-dabble iteration over {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dabble_step(input logic [19:0] work);
        logic [19:0] adj;
        adj = work;
        for (int i = 0; i < 3; i++) begin
            if (adj[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
            end else begin
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4];
            end
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/temp_display_scan_seg7.sv
// BCD to seven-segment decoder; codes above 9 produce a blank digit.
module seg7_decode
    import temp_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Pure lookup from BCD digit to segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/temp_display_scan.sv
// Converts a captured 8-bit temperature to BCD and multiplexes it, plus a
// unit letter, onto a four-digit common seven-segment display.
module temp_display_scan
    import temp_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] temp_in,
    input  logic       temp_valid,
    input  logic       unit_f,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] dig_en
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [19:0] work_q, work_d;
    logic [3:0]  iter_q, iter_d;
    logic        unit_cap_q, unit_cap_d;
    logic [3:0]  disp_h_q, disp_h_d;
    logic [3:0]  disp_t_q, disp_t_d;
    logic [3:0]  disp_o_q, disp_o_d;
    logic        disp_unit_q, disp_unit_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  idx_q, idx_d;

    logic [3:0]  bcd_sel_s;
    logic [7:0]  dec_seg_s;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= 20'd0;
            iter_q      <= 4'd0;
            unit_cap_q  <= 1'b0;
            disp_h_q    <= 4'd0;
            disp_t_q    <= 4'd0;
            disp_o_q    <= 4'd0;
            disp_unit_q <= 1'b0;
            div_q       <= 16'd0;
            idx_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            iter_q      <= iter_d;
            unit_cap_q  <= unit_cap_d;
            disp_h_q    <= disp_h_d;
            disp_t_q    <= disp_t_d;
            disp_o_q    <= disp_o_d;
            disp_unit_q <= disp_unit_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
        end
    end

    // Conversion FSM: capture, eight dabble steps, then publish to display.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        iter_d      = iter_q;
        unit_cap_d  = unit_cap_q;
        disp_h_d    = disp_h_q;
        disp_t_d    = disp_t_q;
        disp_o_d    = disp_o_q;
        disp_unit_d = disp_unit_q;
        case (state_q)
            IDLE: begin
                if (temp_valid) begin
                    work_d     = {12'd0, temp_in};
                    iter_d     = 4'd0;
                    unit_cap_d = unit_f;
                    state_d    = CONV;
                end else begin
                    state_d    = IDLE;
                end
            end
            CONV: begin
                work_d = dabble_step(work_q);
                iter_d = iter_q + 4'd1;
                if (iter_q == ITER_COUNT - 4'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = CONV;
                end
            end
            DONE: begin
                // The only place display content changes, so a scan never mixes values.
                disp_h_d    = work_q[19:16];
                disp_t_d    = work_q[15:12];
                disp_o_d    = work_q[11:8];
                disp_unit_d = unit_cap_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Free-running scan divider, independent of the conversion FSM.
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = 16'd0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Leading-zero blanking on the numeric digits.
    always_comb begin
        bcd_sel_s = BCD_BLANK;
        case (idx_q)
            DIG_HUND: bcd_sel_s = (disp_h_q == 4'd0) ? BCD_BLANK : disp_h_q;
            DIG_TENS: bcd_sel_s = ((disp_h_q == 4'd0) && (disp_t_q == 4'd0)) ? BCD_BLANK : disp_t_q;
            DIG_ONES: bcd_sel_s = disp_o_q;
            default:  bcd_sel_s = BCD_BLANK;
        endcase
    end

    seg7_decode u_seg7 (
        .bcd (bcd_sel_s),
        .seg (dec_seg_s)
    );

    // Segment and digit-enable outputs, decoded from registers only.
    always_comb begin
        dig_en = 4'b0001 << idx_q;
        if (idx_q == DIG_UNIT) begin
            seg = disp_unit_q ? SEG_F : SEG_C;
        end else begin
            seg = dec_seg_s;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_temp_display_scan.sv
// Directed self-checking bench for temp_display_scan with SCAN_DIV = 4.
module tb_temp_display_scan;

    logic       clk;
    logic       rst_n;
    logic [7:0] temp_in;
    logic       temp_valid;
    logic       unit_f;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] dig_en;

    int         n_checks;
    int         n_fail;
    logic [7:0] rd_seg [4];
    logic       rd_ok;
    int         busy_w;

    temp_display_scan #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .unit_f     (unit_f),
        .busy       (busy),
        .seg        (seg),
        .dig_en     (dig_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dig_idx(input logic [3:0] d);
        case (d)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Collects the segment pattern shown for each of the four digit slots.
    task automatic read_display();
        logic [3:0] seen;
        int k;
        seen = 4'h0;
        for (int c = 0; c < 48 && seen != 4'hF; c++) begin
            @(negedge clk);
            k = dig_idx(dig_en);
            if (k >= 0) begin
                rd_seg[k] = seg;
                seen[k] = 1'b1;
            end
        end
        rd_ok = (seen == 4'hF);
    endtask

    // Pulses temp_valid for one capture edge, then measures the busy width.
    task automatic run_conv(input logic [7:0] val, input logic unit);
        @(negedge clk);
        temp_in = val;
        unit_f = unit;
        temp_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        temp_valid = 1'b0;
        busy_w = 0;
        while (busy && busy_w < 40) begin
            busy_w++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] e [4];
        e[0] = 8'h00; e[1] = 8'h00; e[2] = 8'h3F; e[3] = 8'h39;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                repeat (4) @(posedge clk);
                @(negedge clk);
            end
            n_checks++;
            if (dig_en !== (4'b0001 << k)) begin
                n_fail++;
                $display("FAIL reset_dig_en[%0d]: got %b want %b", k, dig_en, 4'b0001 << k);
            end
            n_checks++;
            if (seg !== e[k]) begin
                n_fail++;
                $display("FAIL reset_seg[%0d]: got %h want %h", k, seg, e[k]);
            end
        end
    endtask

    task automatic test_max_f();
        logic [7:0] e [4];
        e[0] = 8'h5B; e[1] = 8'h6D; e[2] = 8'h6D; e[3] = 8'h71;
        run_conv(8'd255, 1'b1);
        n_checks++;
        if (busy_w != 9) begin
            n_fail++;
            $display("FAIL max_busy_width: got %0d want 9", busy_w);
        end
        read_display();
        n_checks++;
        if (!rd_ok) begin
            n_fail++;
            $display("FAIL max_scan_timeout: got incomplete want 4 digits");
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_seg[k] !== e[k]) begin
                n_fail++;
                $display("FAIL max_digit[%0d]: got %h want %h", k, rd_seg[k], e[k]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] e1 [4];
        logic [7:0] e2 [4];
        e1[0] = 8'h06; e1[1] = 8'h3F; e1[2] = 8'h07; e1[3] = 8'h39;
        e2[0] = 8'h00; e2[1] = 8'h00; e2[2] = 8'h6F; e2[3] = 8'h39;
        run_conv(8'd107, 1'b0);
        read_display();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_seg[k] !== e1[k]) begin
                n_fail++;
                $display("FAIL d107_digit[%0d]: got %h want %h", k, rd_seg[k], e1[k]);
            end
        end
        run_conv(8'd9, 1'b0);
        n_checks++;
        if (busy_w != 9) begin
            n_fail++;
            $display("FAIL d9_busy_width: got %0d want 9", busy_w);
        end
        read_display();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_seg[k] !== e2[k]) begin
                n_fail++;
                $display("FAIL d9_digit[%0d]: got %h want %h", k, rd_seg[k], e2[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e50 [4];
        logic [7:0] e60 [4];
        logic       exp_busy [12];
        int         k;
        e50[0] = 8'h00; e50[1] = 8'h6D; e50[2] = 8'h3F; e50[3] = 8'h39;
        e60[0] = 8'h00; e60[1] = 8'h7D; e60[2] = 8'h3F; e60[3] = 8'h39;
        for (int i = 0; i < 12; i++) exp_busy[i] = 1'b1;
        exp_busy[9] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            temp_in = 8'(50 + i);
            unit_f = 1'b0;
            temp_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (busy !== exp_busy[i]) begin
                n_fail++;
                $display("FAIL b2b_busy[%0d]: got %b want %b", i, busy, exp_busy[i]);
            end
            if (i >= 9) begin
                k = dig_idx(dig_en);
                n_checks++;
                if (k < 0 || seg !== e50[(k < 0) ? 0 : k]) begin
                    n_fail++;
                    $display("FAIL b2b_hold50[%0d]: got dig_en=%b seg=%h want value 50", i, dig_en, seg);
                end
            end
        end
        temp_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(posedge clk);
            @(negedge clk);
            k = dig_idx(dig_en);
            n_checks++;
            if (k < 0 || seg !== e50[(k < 0) ? 0 : k]) begin
                n_fail++;
                $display("FAIL b2b_still50[%0d]: got dig_en=%b seg=%h want value 50", j, dig_en, seg);
            end
        end
        busy_w = 0;
        while (busy && busy_w < 40) begin
            busy_w++;
            @(negedge clk);
        end
        n_checks++;
        if (busy_w != 1) begin
            n_fail++;
            $display("FAIL b2b_tail: got %0d busy cycles want 1", busy_w);
        end
        read_display();
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (rd_seg[m] !== e60[m]) begin
                n_fail++;
                $display("FAIL b2b_d60[%0d]: got %h want %h", m, rd_seg[m], e60[m]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] e [4];
        e[0] = 8'h00; e[1] = 8'h00; e[2] = 8'h3F; e[3] = 8'h39;
        @(negedge clk);
        temp_in = 8'd200;
        unit_f = 1'b1;
        temp_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        temp_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || dig_en !== 4'b0001 || seg !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_after_reset: got busy=%b dig_en=%b seg=%h want 0 0001 00", busy, dig_en, seg);
        end
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_busy: got %b want 0", busy);
            end
        end
        read_display();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_seg[k] !== e[k]) begin
                n_fail++;
                $display("FAIL abort_digit[%0d]: got %h want %h", k, rd_seg[k], e[k]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        temp_in = 8'd0;
        temp_valid = 1'b0;
        unit_f = 1'b0;
        test_reset();
        test_max_f();
        test_blanking();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_display_scan.md
TEMP_DISPLAY_SCAN -- requirements
Module: temp_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clk cycles each digit is enabled (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port temp_in  input  8  unsigned temperature value (0..255), already scaled to the selected unit by the upstream SPI/convert stage.
REQ-005 SHALL have port temp_valid  input  1  single-cycle strobe marking temp_in and unit_f valid.
REQ-006 SHALL have port unit_f  input  1  unit of temp_in: 0 = Celsius, 1 = Fahrenheit.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port seg  output  8  active-high segments: bit0 = a … bit6 = g, bit7 = dp.
REQ-009 SHALL have port dig_en  output  4  one-hot active-high digit enable: [0] hundreds, [1] tens, [2] ones, [3] unit letter.

Function
REQ-010 SHALL implement an FSM with states IDLE, CONV and DONE; busy = (state != IDLE).
REQ-011 In IDLE, temp_valid=1 at edge N SHALL capture temp_in and unit_f, clear the BCD work register and iteration count, and enter CONV.
REQ-012 CONV SHALL perform one double-dabble iteration per cycle on edges N+1..N+8: add 3 to each BCD nibble >=5, then shift left 1.
REQ-013 Edge N+8 SHALL enter DONE; edge N+9 SHALL copy hundreds/tens/ones and the unit into display registers and return to IDLE.
REQ-014 Latency SHALL be exactly 9 cycles from the capture edge to new display content; busy SHALL be high for exactly 9 cycles.
REQ-015 temp_valid while busy=1 (CONV or DONE) SHALL be ignored with no effect on state, work register or display.
REQ-016 Display registers SHALL change only at the DONE edge, so no scan period mixes digits from old and new values.
REQ-017 BCD arithmetic SHALL use a 20-bit work register (12 BCD + 8 binary); hundreds SHALL never exceed 2.
REQ-018 A free-running divider SHALL count 0..SCAN_DIV-1 and wrap; on each wrap the 2-bit digit index SHALL advance 0→1→2→3→0.
REQ-019 dig_en SHALL be the one-hot decode of the digit index; seg SHALL decode the digit selected by the index; both SHALL be derived from registers only.
REQ-020 Digit codes SHALL be 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; letter C=0x39, F=0x71; dp SHALL always be 0.
REQ-021 The hundreds digit SHALL be blanked (seg=0x00) when it is 0; tens SHALL be blanked when hundreds and tens are both 0; ones SHALL never be blanked.
REQ-022 Scan timing SHALL be independent of the conversion FSM; a capture coinciding with a divider wrap SHALL perform both actions.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force: state IDLE, busy 0, divider 0, index 0, work register 0, display digits 0, display unit C.
REQ-024 Outputs after reset SHALL be dig_en=4'b0001, seg=0x00 (blanked hundreds); the full scan SHALL show "  0C".
REQ-025 Reset during CONV or DONE SHALL abort the conversion; the captured value SHALL never reach the display.

Structure
REQ-026 Package temp_disp_pkg SHALL hold the FSM state encoding, the digit index constants, the segment codes for 0–9/C/F/blank, and the 4'd8 iteration count.
REQ-027 A combinational sub-module seg7_decode (4-bit BCD in, 8-bit seg out, blank for codes >9) SHALL be instantiated once in the seg output path.

Verification
REQ-028 Reset then no stimulus, SCAN_DIV=4 -> dig_en cycles 0001,0010,0100,1000 every 4 clk; seg 0x00,0x00,0x3F,0x39.
REQ-029 temp_valid with temp_in=255, unit_f=1 -> busy high 9 cycles; then digits 0x5B,0x6D,0x6D and unit 0x71.
REQ-030 temp_in=107 then temp_in=9 (each after busy falls) -> "107C" (tens 0x3F shown), then hundreds and tens blank, ones 0x6F.
REQ-031 temp_valid=1 on all 12 cycles with values 50..61 -> only 50 displayed; pulses during busy ignored; busy pulse width 9.
REQ-032 rst_n=0 at edge N+4 of a conversion of 200 -> after reset release, display "  0C" and busy=0.
